// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter for the shared local bus: grants one master, runs the address/ready/strobe
// handshake, ends unanswered cycles with a watchdog, and supports a per-master bus lock.
module rr_bus_arbiter #(
  parameter int unsigned N_MASTERS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         clrn,
  input  logic [N_MASTERS-1:0]         BARQ,
  input  logic [N_MASTERS-1:0]         BLOCK,
  output logic [N_MASTERS-1:0]         BAGD,
  output logic                         AddressValid,
  input  logic                         TargetReady,
  output logic                         DataStrobe,
  output logic                         Error,
  output logic [$clog2(N_MASTERS)-1:0] ErrorMaster,
  output logic [7:0]                   ErrorCount
);

  localparam int unsigned IW = $clog2(N_MASTERS);

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StWait,
    StStrobe,
    StEnd
  } state_e;

  state_e        state_q;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] winner_q;
  logic [IW-1:0] lock_owner_q;
  logic          lock_valid_q;
  logic          tr_q;
  logic [15:0]   wait_cnt_q;

  logic          tr_edge;
  logic          lock_hit;
  logic          found;
  logic [IW-1:0] pick;
  int unsigned   scan_idx;

  assign tr_edge  = TargetReady & ~tr_q;
  assign lock_hit = lock_valid_q & BARQ[lock_owner_q];

  // Scan from ptr+1 upward with wrap; a live lock overrides the scan.
  always_comb begin
    found    = 1'b0;
    pick     = ptr_q;
    scan_idx = 0;
    for (int unsigned i = 1; i <= N_MASTERS; i++) begin
      scan_idx = 32'(ptr_q) + i;
      if (scan_idx >= N_MASTERS) begin
        scan_idx = scan_idx - N_MASTERS;
      end
      if (!found && BARQ[scan_idx[IW-1:0]]) begin
        found = 1'b1;
        pick  = scan_idx[IW-1:0];
      end
    end
    if (lock_hit) begin
      found = 1'b1;
      pick  = lock_owner_q;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= StIdle;
      ptr_q        <= IW'(N_MASTERS - 1);
      winner_q     <= '0;
      lock_owner_q <= '0;
      lock_valid_q <= 1'b0;
      tr_q         <= 1'b0;
      wait_cnt_q   <= '0;
      BAGD         <= '0;
      AddressValid <= 1'b0;
      DataStrobe   <= 1'b0;
      Error        <= 1'b0;
      ErrorMaster  <= '0;
      ErrorCount   <= '0;
    end else begin
      tr_q <= TargetReady;
      unique case (state_q)
        StIdle: begin
          if (lock_valid_q && !BARQ[lock_owner_q]) begin
            lock_valid_q <= 1'b0;
          end
          if (found) begin
            winner_q <= pick;
            BAGD     <= {{(N_MASTERS - 1){1'b0}}, 1'b1} << pick;
            state_q  <= StGrant;
          end
        end
        StGrant: begin
          AddressValid <= 1'b1;
          wait_cnt_q   <= '0;
          state_q      <= StWait;
        end
        StWait: begin
          // A ready edge beats a coincident timeout.
          if (tr_edge) begin
            DataStrobe <= 1'b1;
            state_q    <= StStrobe;
          end else if (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
            DataStrobe  <= 1'b1;
            Error       <= 1'b1;
            ErrorMaster <= winner_q;
            if (ErrorCount != 8'hFF) begin
              ErrorCount <= ErrorCount + 8'd1;
            end
            state_q <= StStrobe;
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
          end
        end
        StStrobe: begin
          DataStrobe   <= 1'b0;
          Error        <= 1'b0;
          BAGD         <= '0;
          AddressValid <= 1'b0;
          if (BLOCK[winner_q]) begin
            lock_owner_q <= winner_q;
            lock_valid_q <= 1'b1;
          end else begin
            lock_valid_q <= 1'b0;
          end
          state_q <= StEnd;
        end
        StEnd: begin
          // A locked owner keeps the pointer where it was so others regain their turn on release.
          if (!(lock_valid_q && (lock_owner_q == winner_q))) begin
            ptr_q <= winner_q;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Scoreboard bench for rr_bus_arbiter: expected transfer results are queued as stimulus is
// issued and compared whenever the DUT fires DataStrobe.
module tb_rr_bus_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned TMO = 16;

  logic         clk = 1'b0;
  logic         clrn;
  logic [N-1:0] BARQ;
  logic [N-1:0] BLOCK;
  logic [N-1:0] BAGD;
  logic         AddressValid;
  logic         TargetReady;
  logic         DataStrobe;
  logic         Error;
  logic [1:0]   ErrorMaster;
  logic [7:0]   ErrorCount;

  always #5 clk = ~clk;

  rr_bus_arbiter #(
    .N_MASTERS     (N),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .clrn        (clrn),
    .BARQ        (BARQ),
    .BLOCK       (BLOCK),
    .BAGD        (BAGD),
    .AddressValid(AddressValid),
    .TargetReady (TargetReady),
    .DataStrobe  (DataStrobe),
    .Error       (Error),
    .ErrorMaster (ErrorMaster),
    .ErrorCount  (ErrorCount)
  );

  typedef struct packed {
    logic [3:0] grant;
    logic       err;
    logic [1:0] em;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       sb_e;
  int         checks = 0;
  int         errors = 0;
  logic [1:0] m_em;
  logic [7:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (Error && !DataStrobe) check("err_without_strobe", 32'(Error), 32'd0);
    if (DataStrobe) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_strobe", 32'(DataStrobe), 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        check("sb_grant", 32'(BAGD), 32'(sb_e.grant));
        check("sb_error", 32'(Error), 32'(sb_e.err));
        check("sb_err_master", 32'(ErrorMaster), 32'(sb_e.em));
        check("sb_err_count", 32'(ErrorCount), 32'(sb_e.cnt));
      end
    end
  end

  task automatic do_reset();
    BARQ        = '0;
    BLOCK       = '0;
    TargetReady = 1'b0;
    clrn        = 1'b0;
    m_cnt       = '0;
    m_em        = '0;
    sb_q.delete();
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
  endtask

  // dly < 0: never raise TargetReady; otherwise raise it dly cycles after AddressValid is seen.
  task automatic xfer(input logic [3:0] exp_g, input int dly, input logic exp_e, output int cyc);
    int n;
    if (exp_e) begin
      m_cnt = (m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1;
      for (int i = 0; i < 4; i++) if (exp_g[i]) m_em = 2'(i);
    end
    sb_q.push_back({exp_g, exp_e, m_em, m_cnt});
    n = 0;
    while (!AddressValid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("av_seen", 32'(AddressValid), 32'd1);
    check("grant_at_av", 32'(BAGD), 32'(exp_g));
    n = 0;
    while (!DataStrobe && n < int'(TMO) + 8) begin
      if (dly >= 0 && n == dly) TargetReady = 1'b1;
      @(negedge clk);
      n++;
    end
    check("strobe_seen", 32'(DataStrobe), 32'd1);
    cyc         = n;
    TargetReady = 1'b0;
    @(negedge clk);
    check("bus_released", 32'(BAGD), 32'd0);
  endtask

  initial begin
    int cyc;
    int n;
    BARQ        = '0;
    BLOCK       = '0;
    TargetReady = 1'b0;
    clrn        = 1'b0;
    m_cnt       = '0;
    m_em        = '0;
    repeat (2) @(negedge clk);
    check("rst_bagd", 32'(BAGD), 32'd0);
    check("rst_av", 32'(AddressValid), 32'd0);
    check("rst_ds", 32'(DataStrobe), 32'd0);
    check("rst_err", 32'(Error), 32'd0);
    check("rst_em", 32'(ErrorMaster), 32'd0);
    check("rst_ec", 32'(ErrorCount), 32'd0);
    clrn = 1'b1;
    @(negedge clk);

    // Single request, exact latency
    sb_q.push_back({4'b0100, 1'b0, m_em, m_cnt});
    BARQ = 4'b0100;
    @(negedge clk);
    check("t1_bagd_k1", 32'(BAGD), 32'h4);
    check("t1_av_k1", 32'(AddressValid), 32'd0);
    @(negedge clk);
    check("t1_av_k2", 32'(AddressValid), 32'd1);
    repeat (3) @(negedge clk);
    TargetReady = 1'b1;
    @(negedge clk);
    check("t1_ds", 32'(DataStrobe), 32'd1);
    check("t1_err", 32'(Error), 32'd0);
    TargetReady = 1'b0;
    BARQ        = '0;
    @(negedge clk);
    check("t1_release", 32'(BAGD), 32'd0);
    check("t1_ds_pulse", 32'(DataStrobe), 32'd0);
    check("t1_av_drop", 32'(AddressValid), 32'd0);

    // Fairness
    do_reset();
    BARQ = 4'b1111;
    xfer(4'b0001, 0, 1'b0, cyc);
    check("t2_resp_latency", 32'(cyc), 32'd1);
    xfer(4'b0010, 0, 1'b0, cyc);
    xfer(4'b0100, 0, 1'b0, cyc);
    xfer(4'b1000, 0, 1'b0, cyc);
    xfer(4'b0001, 0, 1'b0, cyc);
    BARQ = '0;
    do_reset();
    BARQ = 4'b1010;
    xfer(4'b0010, 1, 1'b0, cyc);
    xfer(4'b1000, 1, 1'b0, cyc);
    xfer(4'b0010, 1, 1'b0, cyc);
    BARQ = '0;

    // Timeout and saturation
    do_reset();
    BARQ = 4'b1000;
    for (int i = 0; i < 260; i++) begin
      xfer(4'b1000, -1, 1'b1, cyc);
      if (i == 0) begin
        check("t3_wait_len", 32'(cyc), 32'(TMO));
        check("t3_ec_first", 32'(ErrorCount), 32'd1);
        check("t3_em_first", 32'(ErrorMaster), 32'd3);
      end
    end
    BARQ = '0;
    check("t3_ec_sat", 32'(ErrorCount), 32'd255);

    // Lock
    do_reset();
    BARQ  = 4'b1010;
    BLOCK = 4'b0010;
    xfer(4'b0010, 2, 1'b0, cyc);
    xfer(4'b0010, 2, 1'b0, cyc);
    xfer(4'b0010, 2, 1'b0, cyc);
    BLOCK = '0;
    xfer(4'b0010, 2, 1'b0, cyc);
    xfer(4'b1000, 2, 1'b0, cyc);
    BARQ = '0;
    do_reset();
    BARQ  = 4'b1010;
    BLOCK = 4'b0010;
    xfer(4'b0010, 0, 1'b0, cyc);
    BARQ  = 4'b1000;
    BLOCK = '0;
    xfer(4'b1000, 0, 1'b0, cyc);
    BARQ = '0;

    // Asynchronous reset during WAIT
    do_reset();
    BARQ = 4'b0100;
    n    = 0;
    while (!AddressValid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t5_av_before", 32'(AddressValid), 32'd1);
    @(negedge clk);
    #2 clrn = 1'b0;
    #1;
    check("t5_bagd", 32'(BAGD), 32'd0);
    check("t5_av", 32'(AddressValid), 32'd0);
    check("t5_ds", 32'(DataStrobe), 32'd0);
    check("t5_err", 32'(Error), 32'd0);
    @(negedge clk);
    m_cnt = '0;
    m_em  = '0;
    BARQ  = 4'b1111;
    clrn  = 1'b1;
    xfer(4'b0001, 0, 1'b0, cyc);

    // Ready already high on entry, then an edge on the final WAIT cycle
    BARQ        = 4'b0100;
    TargetReady = 1'b1;
    xfer(4'b0100, -1, 1'b1, cyc);
    check("t6_held_wait_len", 32'(cyc), 32'(TMO));
    BARQ = 4'b0010;
    xfer(4'b0010, int'(TMO) - 1, 1'b0, cyc);
    check("t6_last_edge_len", 32'(cyc), 32'(TMO));
    BARQ = '0;

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_bus_arbiter.md
Name: rr_bus_arbiter

Overview:
Round-robin arbiter for the shared local bus. It grants one of N masters and runs the address/ready/strobe handshake toward the addressed target. A watchdog ends any cycle that gets no TargetReady, and the block keeps error bookkeeping. A lock input lets one master hold the bus across consecutive transfers. It drops in beside the fixed-priority arbiter, on buses where masters need fair access.

Parameters:
N_MASTERS, 4, number of requesting masters (2..16)
TIMEOUT_CYCLES, 255, maximum WAIT-state cycles before forced strobe (1..65535)

Ports:
clk  in  1  system clock, all logic on rising edge
clrn  in  1  asynchronous active-low reset
BARQ  in  N_MASTERS  bus access requests, level, one per master
BLOCK  in  N_MASTERS  lock request, one per master, sampled with STROBE
BAGD  out  N_MASTERS  bus access granted, one-hot or zero
AddressValid  out  1  address valid to target decoders, one clock after BAGD
TargetReady  in  1  target ready; only a rising edge counts
DataStrobe  out  1  one-clock pulse ending the data phase
Error  out  1  one-clock pulse, coincident with DataStrobe on timeout
ErrorMaster  out  $clog2(N_MASTERS)  index of last master that timed out
ErrorCount  out  8  saturating timeout count

Behaviour:
- Reset (clrn=0, asynchronous): state IDLE; BAGD=0, AddressValid=0, DataStrobe=0, Error=0, ErrorMaster=0, ErrorCount=0; rr pointer=N_MASTERS-1, so master 0 has top priority; lock cleared; TargetReady edge register=0.
- FSM states: IDLE, GRANT, WAIT, STROBE, END.
- IDLE:
  - If the lock is valid and BARQ[lock_owner]=1, the winner is lock_owner.
  - Otherwise the winner is the first requester scanning from pointer+1 upward, with wrap.
  - Winner registered; go to GRANT.
  - No request: stay in IDLE.
- GRANT: BAGD[winner]=1. Go to WAIT.
- WAIT:
  - BAGD held; AddressValid=1. AddressValid rises one cycle after BAGD.
  - Timeout counter is cleared on WAIT entry and increments each WAIT cycle.
  - TargetReady rising edge (TargetReady=1 and previous-cycle value 0) leads to STROBE.
  - If the counter reaches TIMEOUT_CYCLES-1 with no edge, go to STROBE with the timeout flag set. WAIT therefore lasts at most TIMEOUT_CYCLES cycles.
  - Edge and timeout in the same cycle: the edge wins, no error.
- STROBE:
  - DataStrobe=1 for exactly one clock; BAGD and AddressValid stay high.
  - On timeout: Error=1, ErrorMaster=winner, ErrorCount increments and saturates at 255.
  - Lock update: BLOCK[winner]=1 sets lock_owner=winner, valid. Otherwise the lock is cleared.
  - Go to END.
- END:
  - BAGD=0, AddressValid=0, DataStrobe=0, Error=0.
  - pointer=winner, unless the winner was lock_owner with the lock still valid; then the pointer is left unchanged.
  - Go to IDLE.
- Lock release: the lock is cleared in IDLE if BARQ[lock_owner]=0, even when other masters request.
- Latency:
  - BARQ sampled in IDLE at edge k gives BAGD high from cycle k+1 and AddressValid from k+2.
  - Edge seen at cycle t gives DataStrobe at t+1; bus released at t+2.
  - The next grant is earliest at t+4.
- BARQ deasserted mid-transaction is ignored; the transfer completes normally.
- TargetReady already high on WAIT entry is not an edge. The target must drop and re-raise it, otherwise the cycle times out.
- BARQ changes during GRANT/WAIT/STROBE/END do not alter the winner.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Single request: BARQ=0100 held; TargetReady rises 3 cycles after AddressValid → BAGD=0100 at k+1, AddressValid at k+2, DataStrobe one pulse 1 cycle after the edge, BAGD=0000 the next cycle, Error=0.
2. Fairness: BARQ=1111 continuous, target answers each cycle → grant order 0001, 0010, 0100, 1000, 0001. BARQ=1010 from reset → 0010, 1000, 0010.
3. Timeout: TIMEOUT_CYCLES=16, TargetReady=0 forever, master 3 → DataStrobe and Error together after 16 WAIT cycles, ErrorMaster=3, ErrorCount=1. Repeat 260 times → ErrorCount=255, saturated.
4. Lock: BARQ=1010, BLOCK=0010 for three transfers, then BLOCK=0000 → grants 0010, 0010, 0010, 0010, then 1000. Master 1 dropping BARQ while locked → next grant 1000.
5. Reset mid-operation: clrn low between clock edges during WAIT → all outputs 0 immediately. After release with BARQ=1111 → first grant 0001.
6. Edge rules: TargetReady high before AddressValid and held → Error after TIMEOUT_CYCLES. Edge on the final WAIT cycle → DataStrobe with Error=0.
